memory_access_sequencer: RTL

- Clocked front-end sitting directly upstream of the 8-word x 8-bit latch memory unit.
- Accepts read/write requests over a valid/ready handshake. Drives the memory's op/select/address/data lines with a setup/strobe/hold phase sequence so the level-sensitive NAND latches see stable address and data around the select pulse.
- Captures read data off the memory's out_bus and returns one response per request.

---
 rtl/memory_access_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/memory_access_sequencer.sv
// Memory access sequencer: valid/ready request front-end for the 8x8 latch memory.
// Every access runs a SETUP / STROBE / HOLD phase sequence so the level-sensitive
// latches see stable address and data around the select pulse, then one response.
// Optional feature: define WRITE_VERIFY_EN to add a read-back verify pass after writes.
module memory_access_sequencer #(
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STROBE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_op,
  output logic              mem_select,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StResp} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic              sel_q;
  logic              op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept;
  logic              last_strobe;
  logic              need_verify;

  assign accept      = req_valid && ready_q;
  assign last_strobe = (state_q == StStrobe) && (cnt_q == '0);

`ifdef WRITE_VERIFY_EN
  logic write_q;
  logic verify_q;
  logic err_q;

  // A write needs exactly one extra read-back pass before it may respond.
  assign need_verify = write_q && !verify_q;
  assign resp_err    = err_q;

  // Verify-pass bookkeeping: pass flag and read-back compare result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q  <= 1'b0;
      verify_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        write_q  <= req_write;
        verify_q <= 1'b0;
        err_q    <= 1'b0;
      end else if ((state_q == StHold) && need_verify) begin
        verify_q <= 1'b1;
      end
      if (last_strobe && verify_q) begin
        err_q <= (mem_rdata != wdata_q);
      end
    end
  end
`else
  assign need_verify = 1'b0;
  assign resp_err    = 1'b0;
`endif

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the phase sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StSetup;
      StSetup:  state_d = StStrobe;
      StStrobe: if (cnt_q == '0) state_d = StHold;
      StHold:   state_d = need_verify ? StSetup : StResp;
      StResp:   if (resp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Registered datapath: memory-side outputs, strobe counter and response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      sel_q   <= 1'b0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      // Ready and select are decoded from the next state so they line up with it.
      ready_q <= (state_d == StIdle);
      sel_q   <= (state_d == StStrobe);
      if (accept) begin
        op_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end else if ((state_q == StHold) && need_verify) begin
        op_q <= 1'b0;
      end
      if (state_q == StSetup) begin
        cnt_q <= CNT_W'(STROBE_CYC - 1);
      end else if ((state_q == StStrobe) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (last_strobe) begin
        rdata_q <= op_q ? wdata_q : mem_rdata;
      end
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign mem_op     = op_q;
  assign mem_select = sel_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = (state_q != StIdle);

endmodule
